// File: rtl/gpr_ctrl_pkg.sv
// Shared constants for the GPR writeback controller and its round-robin arbiter.
//   REG_ADDR_W   : architectural register address width
//   NUM_GPR      : number of architectural registers (x0 included)
//   DEFAULT_XLEN : default datapath width
//   rr_ptr_w()   : width of the round-robin pointer for n requesters
package gpr_ctrl_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int NUM_GPR      = 32;
    localparam int DEFAULT_XLEN = 64;

    // A pointer over n requesters needs ceil(log2(n)) bits, but never fewer than one.
    function automatic int rr_ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpr_wb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req      : request vector
//   ptr      : index of the highest-priority requester this cycle
//   grant    : one-hot grant, or zero when nothing requests
//   next_ptr : requester after the winner (ptr unchanged when idle)
// The pointer register itself lives in the parent.
module rr_arbiter
    import gpr_ctrl_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]             req,
    input  logic [rr_ptr_w(N)-1:0]   ptr,
    output logic [N-1:0]             grant,
    output logic [rr_ptr_w(N)-1:0]   next_ptr
);

    localparam int PW = rr_ptr_w(N);

    int   idx;
    logic found;

    // Walk ptr, ptr+1, ... wrapping at N; the first requester found wins.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = (idx == N - 1) ? PW'(0) : PW'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/gpr_wb_ctrl.sv
// Writeback controller and RAW scoreboard for the 32-entry GPR block.
//   clk, rst             : clock, synchronous active-high reset
//   issue_valid/issue_rd : an instruction with destination issue_rd issues
//   wb_valid/rd/data     : NREQ writeback requesters (packed slices)
//   wb_ready             : one-hot grant (combinational)
//   gpr_write_en/rd_addr, gpr_rd_data : registered GPR write port
//   rs1/rs2_addr -> rs1/rs2_busy : per-source pending-writeback query
//   busy_vec             : full scoreboard, bit 0 always 0
module gpr_wb_ctrl
    import gpr_ctrl_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    input  logic [NREQ-1:0]               wb_valid,
    input  logic [NREQ*REG_ADDR_W-1:0]    wb_rd,
    input  logic [NREQ*XLEN-1:0]          wb_data,
    output logic [NREQ-1:0]               wb_ready,
    output logic                          gpr_write_en,
    output logic [REG_ADDR_W-1:0]         gpr_write_rd_addr,
    output logic [XLEN-1:0]               gpr_rd_data,
    input  logic [REG_ADDR_W-1:0]         rs1_addr,
    input  logic [REG_ADDR_W-1:0]         rs2_addr,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic [NUM_GPR-1:0]            busy_vec
);

    localparam int PW = rr_ptr_w(NREQ);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [PW-1:0]   ptr_reg, ptr_next, arb_next_ptr;
    logic [NREQ-1:0] grant;
    logic            transfer;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req      (wb_valid),
        .ptr      (ptr_reg),
        .grant    (grant),
        .next_ptr (arb_next_ptr)
    );

    assign wb_ready = grant;
    assign transfer = |grant;
    assign ptr_next = transfer ? arb_next_ptr : ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Granted-slice select (grant is one-hot, so an OR-mux suffices)
    // ------------------------------------------------------------------
    logic [REG_ADDR_W-1:0] req_rd   [NREQ];
    logic [XLEN-1:0]       req_data [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign req_rd[gi]   = wb_rd[gi*REG_ADDR_W +: REG_ADDR_W];
        assign req_data[gi] = wb_data[gi*XLEN +: XLEN];
    end

    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd   = sel_rd | req_rd[i];
                sel_data = sel_data | req_data[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // GPR write-port register
    // ------------------------------------------------------------------
    logic                  write_en_reg,   write_en_next;
    logic [REG_ADDR_W-1:0] write_addr_reg, write_addr_next;
    logic [XLEN-1:0]       write_data_reg, write_data_next;

    // A transfer to x0 still loads address/data but never raises write enable.
    always_comb begin
        write_en_next   = 1'b0;
        write_addr_next = write_addr_reg;
        write_data_next = write_data_reg;
        if (transfer) begin
            write_en_next   = (sel_rd != '0);
            write_addr_next = sel_rd;
            write_data_next = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_en_reg   <= 1'b0;
            write_addr_reg <= '0;
            write_data_reg <= '0;
        end else begin
            write_en_reg   <= write_en_next;
            write_addr_reg <= write_addr_next;
            write_data_reg <= write_data_next;
        end
    end

    assign gpr_write_en      = write_en_reg;
    assign gpr_write_rd_addr = write_addr_reg;
    assign gpr_rd_data       = write_data_reg;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    // Clear follows the registered write port so the busy bit drops on the
    // same edge the GPR cell updates. The set is applied after the clear so a
    // new producer issuing on that edge keeps the register busy.
    logic [NUM_GPR-1:0] busy_reg, busy_next;

    always_comb begin
        busy_next = busy_reg;
        if (write_en_reg) begin
            busy_next[write_addr_reg] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_vec = busy_reg;
    assign rs1_busy = busy_reg[rs1_addr];
    assign rs2_busy = busy_reg[rs2_addr];

endmodule
